fare_calc: RTL

FARE_CALC -- requirements
Module: fare_calc

---
 rtl/fare_calc.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/fare_calc.sv
// Taxi fare calculator: flag-fall, per-distance and waiting charges.
// Optional night tariff enabled by defining NIGHT_RATE_EN.
module fare_calc #(
  parameter int TICKS_PER_SEC = 50000000,
  parameter int BASE_FARE     = 80,
  parameter int BASE_DIST     = 30,
  parameter int UNIT_PRICE    = 2,
  parameter int STALL_SEC     = 3,
  parameter int WAIT_SEC      = 60,
  parameter int WAIT_PRICE    = 5
) (
  input  logic        clk,
  input  logic        sys_reset,
  input  logic        start_p,
  input  logic        end_p,
  input  logic        wheel,
  input  logic [1:0]  disp_sel,
  input  logic        night,
  output logic [15:0] data,
  output logic [3:0]  point,
  output logic [1:0]  trip_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } state_t;

  localparam int STALL_LIM = STALL_SEC * TICKS_PER_SEC;
  localparam int SW = $clog2(STALL_LIM + 1);
  localparam int TW = $clog2(TICKS_PER_SEC + 1);
  localparam int CW = $clog2(WAIT_SEC + 1);

  localparam logic [SW-1:0] STALL_END = SW'(STALL_LIM - 1);
  localparam logic [TW-1:0] TICK_END  = TW'(TICKS_PER_SEC - 1);
  localparam logic [CW-1:0] CHG_END   = CW'(WAIT_SEC - 1);

  localparam logic [13:0] MAXV   = 14'd9999;
  localparam logic [13:0] BASE_F = 14'(BASE_FARE);
  localparam logic [13:0] BASE_D = 14'(BASE_DIST);
  localparam logic [13:0] UNIT_P = 14'(UNIT_PRICE);
  localparam logic [13:0] WAIT_P = 14'(WAIT_PRICE);

  function automatic logic [13:0] sat_add(
    input logic [13:0] a,
    input logic [13:0] b
  );
    logic [14:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s > {1'b0, MAXV}) ? MAXV : s[13:0];
  endfunction

  state_t        state_q, state_d;
  logic [13:0]   fare_q, fare_d;
  logic [13:0]   dist_q, dist_d;
  logic [13:0]   wsec_q, wsec_d;
  logic [CW-1:0] wchg_q, wchg_d;
  logic [SW-1:0] stall_q, stall_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [2:0]    w_sync;
  logic          wheel_evt;
  logic [13:0]   price;
  logic [13:0]   dist_inc;
  logic          dist_chg;
  logic [13:0]   fare_mv;
  logic [13:0]   sel_val;
  logic [15:0]   data_d;
  logic [3:0]    point_d;

`ifdef NIGHT_RATE_EN
  assign price = night ? sat_add(UNIT_P, 14'd1) : UNIT_P;
`else
  logic unused_night;
  assign unused_night = night;
  assign price = UNIT_P;
`endif

  assign wheel_evt = w_sync[1] & ~w_sync[2];
  assign dist_inc  = sat_add(dist_q, 14'd1);
  assign dist_chg  = (dist_q != MAXV) && (dist_inc > BASE_D);
  assign fare_mv   = dist_chg ? sat_add(fare_q, price) : fare_q;

  // Wheel synchronizer and edge-detect delay stage
  always_ff @(posedge clk or negedge sys_reset) begin
    if (!sys_reset) w_sync <= 3'b000;
    else            w_sync <= {w_sync[1:0], wheel};
  end

  // Trip state and counter registers
  always_ff @(posedge clk or negedge sys_reset) begin
    if (!sys_reset) begin
      state_q <= IDLE;
      fare_q  <= '0;
      dist_q  <= '0;
      wsec_q  <= '0;
      wchg_q  <= '0;
      stall_q <= '0;
      tick_q  <= '0;
    end else begin
      state_q <= state_d;
      fare_q  <= fare_d;
      dist_q  <= dist_d;
      wsec_q  <= wsec_d;
      wchg_q  <= wchg_d;
      stall_q <= stall_d;
      tick_q  <= tick_d;
    end
  end

  // Next-state, metering and timer logic
  always_comb begin
    state_d = state_q;
    fare_d  = fare_q;
    dist_d  = dist_q;
    wsec_d  = wsec_q;
    wchg_d  = wchg_q;
    stall_d = stall_q;
    tick_d  = tick_q;
    unique case (state_q)
      IDLE: begin
        if (start_p && !end_p) begin
          state_d = RUN;
          fare_d  = BASE_F;
          dist_d  = '0;
          wsec_d  = '0;
          wchg_d  = '0;
          stall_d = '0;
          tick_d  = '0;
        end
      end
      RUN: begin
        if (end_p) begin
          state_d = HOLD;
        end else if (wheel_evt) begin
          dist_d  = dist_inc;
          fare_d  = fare_mv;
          stall_d = '0;
        end else if (stall_q == STALL_END) begin
          state_d = WAIT;
          stall_d = '0;
          tick_d  = '0;
        end else begin
          stall_d = stall_q + 1'b1;
        end
      end
      WAIT: begin
        if (end_p) begin
          state_d = HOLD;
        end else if (wheel_evt) begin
          state_d = RUN;
          dist_d  = dist_inc;
          fare_d  = fare_mv;
          stall_d = '0;
          tick_d  = '0;
        end else if (tick_q == TICK_END) begin
          tick_d = '0;
          wsec_d = sat_add(wsec_q, 14'd1);
          if (wchg_q == CHG_END) begin
            wchg_d = '0;
            fare_d = sat_add(fare_q, WAIT_P);
          end else begin
            wchg_d = wchg_q + 1'b1;
          end
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      HOLD: begin
        if (end_p) begin
          state_d = IDLE;
          fare_d  = '0;
          dist_d  = '0;
          wsec_d  = '0;
          wchg_d  = '0;
          stall_d = '0;
          tick_d  = '0;
        end else if (start_p) begin
          state_d = RUN;
          fare_d  = BASE_F;
          dist_d  = '0;
          wsec_d  = '0;
          wchg_d  = '0;
          stall_d = '0;
          tick_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Display value and decimal-point selection
  always_comb begin
    sel_val = fare_q;
    point_d = 4'b0010;
    unique case (disp_sel)
      2'd1: sel_val = dist_q;
      2'd2: begin
        sel_val = wsec_q / 14'd60;
        point_d = 4'b0000;
      end
      default: sel_val = fare_q;
    endcase
    data_d = (state_q == IDLE) ? 16'd0 : {2'b00, sel_val};
  end

  // Registered display outputs
  always_ff @(posedge clk or negedge sys_reset) begin
    if (!sys_reset) begin
      data  <= '0;
      point <= '0;
    end else begin
      data  <= data_d;
      point <= point_d;
    end
  end

  assign trip_state = state_q;

endmodule
